// File: rtl/id_exe_reg.sv
// ============================================================================
// id_exe_reg
// ----------------------------------------------------------------------------
// ID->EXE pipeline register of the ARM-subset core. It captures the decoded
// control bits, the register operands and the 12-bit shift_operand that the
// EXE stage uses for Val2 generation and the ALU.
//
// Each rising edge does one of three things, in this priority order:
//   flush  - the stage becomes a bubble: every output is cleared
//   freeze - the stage keeps its contents (hazard stall)
//   load   - id_* is copied to exe_*; if id_valid is 0, the control bits
//            are forced to 0 but the datapath fields still load
// bubble_cnt counts every edge that writes a bubble (a flush, or a load with
// id_valid=0). It saturates at all-ones and does not wrap.
//
// Parameters
//   DATA_W : operand / PC width (default 32)
//   CNT_W  : bubble counter width (default 16)
//
// Optional feature macro
//   ID_EXE_FWD_EN : adds id_src1/id_src2/id_two_src inputs and the registered
//                   exe_src1/exe_src2/exe_two_src outputs for the forwarding
//                   unit. These fields are cleared on every bubble.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   freeze, flush             stall / squash controls
//   id_valid .. id_sr         decoded instruction from the ID stage
//   exe_valid .. exe_sr       registered copies for the EXE stage
//   bubble_cnt                saturating count of bubbles inserted
// ============================================================================
module id_exe_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [3:0]        id_exe_cmd,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_b,
    input  logic              id_s,
    input  logic              id_imm,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic [11:0]       id_shift_op,
    input  logic [23:0]       id_imm24,
    input  logic [3:0]        id_dest,
    input  logic [3:0]        id_sr,
`ifdef ID_EXE_FWD_EN
    input  logic [3:0]        id_src1,
    input  logic [3:0]        id_src2,
    input  logic              id_two_src,
    output logic [3:0]        exe_src1,
    output logic [3:0]        exe_src2,
    output logic              exe_two_src,
`endif
    output logic              exe_valid,
    output logic [DATA_W-1:0] exe_pc,
    output logic [3:0]        exe_exe_cmd,
    output logic              exe_wb_en,
    output logic              exe_mem_r_en,
    output logic              exe_mem_w_en,
    output logic              exe_b,
    output logic              exe_s,
    output logic              exe_imm,
    output logic [DATA_W-1:0] exe_val_rn,
    output logic [DATA_W-1:0] exe_val_rm,
    output logic [11:0]       exe_shift_op,
    output logic [23:0]       exe_imm24,
    output logic [3:0]        exe_dest,
    output logic [3:0]        exe_sr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A bubble is written on this edge when flush is active (flush overrides
    // freeze), or when the stage loads an ID slot that holds no instruction.
    logic bubble_wr;
    assign bubble_wr = flush | (~freeze & ~id_valid);

    // Main stage register. Control bits are ANDed with id_valid on load, so a
    // cleared exe_valid always comes with cleared wb/mem/branch/flag enables.
    // exe_cmd and imm are treated as datapath fields: they clear on flush and
    // still load when id_valid is 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            exe_valid    <= 1'b0;
            exe_wb_en    <= 1'b0;
            exe_mem_r_en <= 1'b0;
            exe_mem_w_en <= 1'b0;
            exe_b        <= 1'b0;
            exe_s        <= 1'b0;
            exe_pc       <= '0;
            exe_exe_cmd  <= '0;
            exe_imm      <= 1'b0;
            exe_val_rn   <= '0;
            exe_val_rm   <= '0;
            exe_shift_op <= '0;
            exe_imm24    <= '0;
            exe_dest     <= '0;
            exe_sr       <= '0;
        end else if (!freeze) begin
            exe_valid    <= id_valid;
            exe_wb_en    <= id_valid & id_wb_en;
            exe_mem_r_en <= id_valid & id_mem_r_en;
            exe_mem_w_en <= id_valid & id_mem_w_en;
            exe_b        <= id_valid & id_b;
            exe_s        <= id_valid & id_s;
            exe_pc       <= id_pc;
            exe_exe_cmd  <= id_exe_cmd;
            exe_imm      <= id_imm;
            exe_val_rn   <= id_val_rn;
            exe_val_rm   <= id_val_rm;
            exe_shift_op <= id_shift_op;
            exe_imm24    <= id_imm24;
            exe_dest     <= id_dest;
            exe_sr       <= id_sr;
        end
    end

`ifdef ID_EXE_FWD_EN
    // Source register tags for the forwarding unit. They are cleared on any
    // bubble, including a load with id_valid=0, so that a dead slot can never
    // match a producer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble_wr) begin
            exe_src1    <= '0;
            exe_src2    <= '0;
            exe_two_src <= 1'b0;
        end else if (!freeze) begin
            exe_src1    <= id_src1;
            exe_src2    <= id_src2;
            exe_two_src <= id_two_src;
        end
    end
`endif

    // Saturating bubble counter. It holds at all-ones so that long runs of
    // stalls never wrap back to a small value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (bubble_wr && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule
